// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: two-requester round-robin arbiter and sequencer for one
// shared N-bit load/clear register. A clear request or the winning write is
// turned into a single-cycle reg_clr/reg_ld strobe, followed by a one-cycle ack.
// Optional macro ARB_LOCK_EN: a requester that won last and holds its lock bit
// keeps winning while it requests (clear still has priority).
module shared_reg_arbiter #(
  parameter int N = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [N-1:0] din0,
  input  logic [N-1:0] din1,
  input  logic         clr_req,
  input  logic [1:0]   lock,
  output logic [1:0]   gnt,
  output logic         ack,
  output logic         reg_ld,
  output logic         reg_clr,
  output logic [N-1:0] reg_in
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t       state_reg, state_next;
  logic         ptr_reg, ptr_next;
  logic [1:0]   gnt_next;
  logic         ack_next;
  logic         ld_next;
  logic         clr_next;
  logic [N-1:0] in_next;

  logic         win_valid;
  logic         win;

  // Winner selection among write requesters: a lone requester wins, a tie goes
  // to the requester that did not win last time (ptr_reg holds the last winner).
  always_comb begin
    win_valid = |req;
    win       = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~ptr_reg;
      default: win = 1'b0;
    endcase
`ifdef ARB_LOCK_EN
    // Locked last winner that is still requesting keeps the register.
    if (lock[ptr_reg] && req[ptr_reg]) begin
      win = ptr_reg;
    end
`endif
  end

`ifndef ARB_LOCK_EN
  // Lock inputs have no function in the round-robin-only build.
  logic lock_unused;
  assign lock_unused = ^lock;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt;
    ack_next   = 1'b0;
    ld_next    = 1'b0;
    clr_next   = 1'b0;
    in_next    = reg_in;
    case (state_reg)
      IDLE: begin
        gnt_next = 2'b00;
        if (clr_req) begin
          // Clear outranks any write, locked or not.
          state_next = CLEAR;
          clr_next   = 1'b1;
        end else if (win_valid) begin
          state_next = WRITE;
          gnt_next   = win ? 2'b10 : 2'b01;
          in_next    = win ? din1 : din0;
          ld_next    = 1'b1;
          ptr_next   = win;
        end
      end
      CLEAR: begin
        // Register is cleared at the end of this cycle; acknowledge next.
        gnt_next   = 2'b00;
        ack_next   = 1'b1;
        state_next = ACK;
      end
      WRITE: begin
        // Register loads at the end of this cycle; gnt and reg_in stay put.
        ack_next   = 1'b1;
        state_next = ACK;
      end
      ACK: begin
        gnt_next   = 2'b00;
        state_next = IDLE;
      end
      default: begin
        gnt_next   = 2'b00;
        state_next = IDLE;
      end
    endcase
  end

  // State, pointer and output registers; reset clears everything immediately
  // so any in-flight strobe is dropped before the shared register samples it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b1;
      gnt       <= 2'b00;
      ack       <= 1'b0;
      reg_ld    <= 1'b0;
      reg_clr   <= 1'b0;
      reg_in    <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gnt       <= gnt_next;
      ack       <= ack_next;
      reg_ld    <= ld_next;
      reg_clr   <= clr_next;
      reg_in    <= in_next;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed testbench for shared_reg_arbiter with a behavioural shared register.
module tb_shared_reg_arbiter;

  localparam int N = 12;

  logic         clk;
  logic         rst;
  logic [1:0]   req;
  logic [N-1:0] din0;
  logic [N-1:0] din1;
  logic         clr_req;
  logic [1:0]   lock;
  logic [1:0]   gnt;
  logic         ack;
  logic         reg_ld;
  logic         reg_clr;
  logic [N-1:0] reg_in;

  logic [N-1:0] shreg;
  logic [16:0]  obs;
  logic [16:0]  exp_v;
  int vectors;
  int miscompares;

  shared_reg_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .din0(din0), .din1(din1),
    .clr_req(clr_req), .lock(lock), .gnt(gnt), .ack(ack),
    .reg_ld(reg_ld), .reg_clr(reg_clr), .reg_in(reg_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared register: not reset by the arbiter reset.
  always @(posedge clk) begin
    if (reg_clr) shreg <= '0;
    else if (reg_ld) shreg <= reg_in;
  end

  assign obs = {gnt, ack, reg_ld, reg_clr, reg_in};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; din0 = '0; din1 = '0; clr_req = 1'b0; lock = 2'b00;
    shreg = 12'hEEE;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (obs !== 17'h0) begin miscompares++; $display("FAIL reset_async obs=%h exp=%h", obs, 17'h0); end
    tick();
    vectors++;
    if (obs !== 17'h0) begin miscompares++; $display("FAIL reset_held obs=%h exp=%h", obs, 17'h0); end
    #3 rst = 1'b1;
    tick();
    vectors++;
    if (obs !== 17'h0) begin miscompares++; $display("FAIL reset_idle obs=%h exp=%h", obs, 17'h0); end
  endtask

  task automatic test_tie();
    req = 2'b11; din0 = 12'h0A5; din1 = 12'h5A0;
    tick();
    exp_v = {2'b01, 1'b0, 1'b1, 1'b0, 12'h0A5};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL tie_write0 obs=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {2'b01, 1'b1, 1'b0, 1'b0, 12'h0A5};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL tie_ack0 obs=%h exp=%h", obs, exp_v); end
    vectors++;
    if (shreg !== 12'h0A5) begin miscompares++; $display("FAIL tie_reg0 reg=%h exp=%h", shreg, 12'h0A5); end
    tick();
    vectors++;
    if (obs[16:12] !== 5'b0) begin miscompares++; $display("FAIL tie_idle0 ctl=%b exp=%b", obs[16:12], 5'b0); end
    tick();
    exp_v = {2'b10, 1'b0, 1'b1, 1'b0, 12'h5A0};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL tie_write1 obs=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {2'b10, 1'b1, 1'b0, 1'b0, 12'h5A0};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL tie_ack1 obs=%h exp=%h", obs, exp_v); end
    vectors++;
    if (shreg !== 12'h5A0) begin miscompares++; $display("FAIL tie_reg1 reg=%h exp=%h", shreg, 12'h5A0); end
    req = 2'b00;
    tick();
    $display("tie: grants 01 then 10, reg=%h", shreg);
  endtask

  task automatic test_single();
    req = 2'b10; din1 = 12'hFFF;
    tick();
    exp_v = {2'b10, 1'b0, 1'b1, 1'b0, 12'hFFF};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL single_write obs=%h exp=%h", obs, exp_v); end
    tick();
    vectors++;
    if (ack !== 1'b1 || shreg !== 12'hFFF) begin miscompares++; $display("FAIL single_ack ack=%b reg=%h exp ack=1 reg=fff", ack, shreg); end
    req = 2'b11;
    tick();
    tick();
    exp_v = {2'b01, 1'b0, 1'b1, 1'b0, 12'h0A5};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL single_next_tie obs=%h exp=%h", obs, exp_v); end
    tick();
    vectors++;
    if (ack !== 1'b1 || shreg !== 12'h0A5) begin miscompares++; $display("FAIL single_next_ack ack=%b reg=%h exp ack=1 reg=0a5", ack, shreg); end
    req = 2'b00;
    tick();
    $display("single: req1 alone then tie to req0, reg=%h", shreg);
  endtask

  task automatic test_clear();
    clr_req = 1'b1; req = 2'b01; din0 = 12'h0A5;
    tick();
    vectors++;
    if (obs[16:12] !== 5'b00001) begin miscompares++; $display("FAIL clear_strobe ctl=%b exp=%b", obs[16:12], 5'b00001); end
    tick();
    vectors++;
    if (obs[16:12] !== 5'b00100 || shreg !== 12'h000) begin miscompares++; $display("FAIL clear_ack ctl=%b reg=%h exp ctl=00100 reg=000", obs[16:12], shreg); end
    clr_req = 1'b0;
    tick();
    tick();
    exp_v = {2'b01, 1'b0, 1'b1, 1'b0, 12'h0A5};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL clear_then_write obs=%h exp=%h", obs, exp_v); end
    tick();
    vectors++;
    if (ack !== 1'b1 || shreg !== 12'h0A5) begin miscompares++; $display("FAIL clear_then_ack ack=%b reg=%h exp ack=1 reg=0a5", ack, shreg); end
    req = 2'b00;
    tick();
    $display("clear: clear served before write, reg=%h", shreg);
  endtask

  task automatic test_reset_mid();
    req = 2'b11; din0 = 12'h111; din1 = 12'h222;
    tick();
    exp_v = {2'b10, 1'b0, 1'b1, 1'b0, 12'h222};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL midrst_write obs=%h exp=%h", obs, exp_v); end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (obs !== 17'h0) begin miscompares++; $display("FAIL midrst_async obs=%h exp=%h", obs, 17'h0); end
    req = 2'b00;
    tick();
    vectors++;
    if (obs !== 17'h0 || shreg !== 12'h0A5) begin miscompares++; $display("FAIL midrst_noack obs=%h reg=%h exp obs=0 reg=0a5", obs, shreg); end
    #3 rst = 1'b1;
    req = 2'b11; din0 = 12'h333; din1 = 12'h444;
    tick();
    exp_v = {2'b01, 1'b0, 1'b1, 1'b0, 12'h333};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL midrst_tie obs=%h exp=%h", obs, exp_v); end
    tick();
    vectors++;
    if (ack !== 1'b1 || shreg !== 12'h333) begin miscompares++; $display("FAIL midrst_ack ack=%b reg=%h exp ack=1 reg=333", ack, shreg); end
    req = 2'b00;
    tick();
    $display("reset_mid: write aborted, tie after reset to req0, reg=%h", shreg);
  endtask

  task automatic test_din_hold();
    req = 2'b01; din0 = 12'h123;
    tick();
    din0 = 12'h456;
    exp_v = {2'b01, 1'b0, 1'b1, 1'b0, 12'h123};
    vectors++;
    if (obs !== exp_v) begin miscompares++; $display("FAIL dinhold_write obs=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {2'b01, 1'b1, 1'b0, 1'b0, 12'h123};
    vectors++;
    if (obs !== exp_v || shreg !== 12'h123) begin miscompares++; $display("FAIL dinhold_ack obs=%h reg=%h exp obs=%h reg=123", obs, shreg, exp_v); end
    req = 2'b00;
    tick();
    $display("din_hold: reg=%h", shreg);
  endtask

  task automatic test_lock();
    logic [1:0] exp_g2;
`ifdef ARB_LOCK_EN
    exp_g2 = 2'b01;
`else
    exp_g2 = 2'b10;
`endif
    // Make requester 1 the last winner first.
    req = 2'b10; din1 = 12'h0BB;
    tick();
    tick();
    vectors++;
    if (gnt !== 2'b10 || shreg !== 12'h0BB) begin miscompares++; $display("FAIL lock_pre gnt=%b reg=%h exp gnt=10 reg=0bb", gnt, shreg); end
    req = 2'b11; lock = 2'b01; din0 = 12'h0AA;
    tick();
    tick();
    vectors++;
    if (gnt !== 2'b01 || reg_ld !== 1'b1) begin miscompares++; $display("FAIL lock_first gnt=%b ld=%b exp gnt=01 ld=1", gnt, reg_ld); end
    tick();
    tick();
    tick();
    vectors++;
    if (gnt !== exp_g2 || reg_ld !== 1'b1) begin miscompares++; $display("FAIL lock_second gnt=%b ld=%b exp gnt=%b ld=1", gnt, reg_ld, exp_g2); end
    tick();
    req = 2'b00; lock = 2'b00;
    tick();
    $display("lock: second grant %b", gnt);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_tie();
    test_single();
    test_clear();
    test_reset_mid();
    test_din_hold();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one shared N-bit load/clear register.
- Samples write and clear requests, selects one winner, and drives the register's `ld`/`clr`/`in` for exactly one cycle.
- Returns a one-cycle `ack` once the register holds the new value.
- Sits between two datapath producers and the shared register in the lab-exam datapath.

Parameters:
- N, 12, data width of the shared register and of both data inputs.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  2  write request per requester; bit i = requester i; level, held until ack.
- din0  input  N  write data from requester 0.
- din1  input  N  write data from requester 1.
- clr_req  input  1  request to clear the shared register; level, held until ack.
- lock  input  2  grant-lock per requester; used only with ARB_LOCK_EN, ignored otherwise.
- gnt  output  2  one-hot grant; 2'b00 when nobody is granted.
- ack  output  1  one-cycle pulse: the shared register now holds the granted value (or 0 after a clear).
- reg_ld  output  1  load strobe to the shared register.
- reg_clr  output  1  clear strobe to the shared register.
- reg_in  output  N  data to the shared register.

Behaviour:
- Reset: rst low forces, immediately, state=IDLE, gnt=0, ack=0, reg_ld=0, reg_clr=0, reg_in=0, last-grant pointer ptr=1 (requester 0 wins the first tie).
- Reset takes effect mid-transaction: the in-flight strobe is dropped, no ack is issued, and the register holds its pre-reset value.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, CLEAR, WRITE, ACK.
- IDLE with clr_req=1:
  - Goes to CLEAR; clear has priority over writes.
  - CLEAR: reg_clr=1 for one cycle, gnt=0; next state ACK.
- IDLE with clr_req=0 and req!=0:
  - Winner is the only requester if exactly one is active.
  - If both are active, winner is the requester != ptr.
  - Goes to WRITE with gnt=onehot(winner), reg_in=din of winner sampled at that edge, reg_ld=1, ptr<=winner.
- WRITE lasts one cycle, then goes to ACK: reg_ld=0, reg_in held, gnt held, ack=1.
- ACK lasts one cycle, then returns to IDLE: gnt=0, ack=0.
- Latency: a request sampled at edge k gives reg_ld/reg_clr high during cycle k..k+1. The register updates at edge k+1; ack is high during k+1..k+2.
- Minimum spacing between strobes is 3 cycles.
- Requesters must drop req/clr_req on the edge after seeing ack. A req still high in IDLE is a new request.
- Request or clr_req dropped during WRITE/CLEAR: ignored, transaction completes and ack still pulses.
- clr_req raised during WRITE/ACK: waits and is served in the next IDLE.
- din changes after the grant edge do not affect reg_in.
- reg_ld and reg_clr are never high together.
- gnt is at most one-hot and is 0 in IDLE and CLEAR.
- No transaction is accepted in WRITE/ACK.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined: if the requester granted last has lock[ptr]=1 and req[ptr]=1 in IDLE, it wins again regardless of the other request, bypassing round-robin. clr_req still has priority over a locked requester.
- Undefined: lock port present but ignored; pure round-robin.

Test Plan:
- Reset then req=2'b11, din0=12'h0A5, din1=12'h5A0 held -> first grant gnt=01, reg_ld=1 one cycle, reg_in=0A5, ack next cycle. After IDLE, gnt=10 with reg_in=5A0.
- req=2'b10 alone, din1=12'hFFF -> gnt=10, register output FFF when ack=1, ptr=1. A following req=2'b11 grants requester 0.
- clr_req=1 together with req=2'b01 in IDLE -> CLEAR first: reg_clr=1, gnt=00, ack, register 0. The write to requester 0 follows.
- rst pulsed low during WRITE -> outputs 0 asynchronously, no ack, register keeps its prior value. After release, a 2'b11 tie grants requester 0.
- din0 changed from 12'h123 to 12'h456 the cycle after grant -> register loads 123.
- ARB_LOCK_EN defined, lock=2'b01, req=2'b11 held through two transactions -> requester 0 granted twice consecutively. Undefined -> alternates 01, 10.
